// File: rtl/karatsuba_seq_ctrl_if.sv
// Operand, sub-multiplier and result handshake bundle for karatsuba_seq_ctrl.
// master is the sequencer's view; slave is the operand source / multiplier / consumer side.
interface karatsuba_seq_ctrl_if #(
    parameter int W = 256
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             mul_valid;
    logic [W/2:0]     mul_a;
    logic [W/2:0]     mul_b;
    logic             mul_done;
    logic [W+1:0]     mul_p;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   result;
    logic             busy;
    logic [15:0]      op_count;

    modport master (
        input  in_valid, a, b, mul_done, mul_p, out_ready,
        output in_ready, mul_valid, mul_a, mul_b, out_valid, result, busy, op_count
    );

    modport slave (
        output in_valid, a, b, mul_done, mul_p, out_ready,
        input  in_ready, mul_valid, mul_a, mul_b, out_valid, result, busy, op_count
    );
endinterface

// File: rtl/karatsuba_seq_ctrl.sv
// Sequential one-level Karatsuba multiplier: three sub-products through a shared port, then recombine.
// Result valid 5 cycles after accept with a zero-wait multiplier; held in DONE until out_ready.
module karatsuba_seq_ctrl #(
    parameter int W = 256
) (
    input  logic                clk,
    input  logic                rst,
    karatsuba_seq_ctrl_if.master bus
);
    localparam int H = W / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_M0,
        S_M1,
        S_M2,
        S_COMB,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [H-1:0]     a0_q, a0_d, a1_q, a1_d;
    logic [H-1:0]     b0_q, b0_d, b1_q, b1_d;
    logic [W+1:0]     t0_q, t0_d, t1_q, t1_d, tm_q, tm_d;
    logic [2*W-1:0]   result_q, result_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             mul_valid;
    logic [H:0]       mul_a, mul_b;
    logic [2*W+1:0]   t0_x, t1_x, tm_x, comb_sum;

    // Middle term tm - t0 - t1 is never negative, so the wide sum is exact.
    assign t0_x     = {{W{1'b0}}, t0_q};
    assign t1_x     = {{W{1'b0}}, t1_q};
    assign tm_x     = {{W{1'b0}}, tm_q};
    assign comb_sum = (t1_x << W) + ((tm_x - t0_x - t1_x) << H) + t0_x;

    always_comb begin
        state_d    = state_q;
        a0_d       = a0_q;
        a1_d       = a1_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        t0_d       = t0_q;
        t1_d       = t1_q;
        tm_d       = tm_q;
        result_d   = result_q;
        op_count_d = op_count_q;
        mul_valid  = 1'b0;
        mul_a      = '0;
        mul_b      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a0_d    = bus.a[H-1:0];
                    a1_d    = bus.a[W-1:H];
                    b0_d    = bus.b[H-1:0];
                    b1_d    = bus.b[W-1:H];
                    state_d = S_M0;
                end
            end
            S_M0: begin
                mul_valid = 1'b1;
                mul_a     = {1'b0, a0_q};
                mul_b     = {1'b0, b0_q};
                if (bus.mul_done) begin
                    t0_d    = bus.mul_p;
                    state_d = S_M1;
                end
            end
            S_M1: begin
                mul_valid = 1'b1;
                mul_a     = {1'b0, a1_q};
                mul_b     = {1'b0, b1_q};
                if (bus.mul_done) begin
                    t1_d    = bus.mul_p;
                    state_d = S_M2;
                end
            end
            S_M2: begin
                mul_valid = 1'b1;
                mul_a     = {1'b0, a0_q} + {1'b0, a1_q};
                mul_b     = {1'b0, b0_q} + {1'b0, b1_q};
                if (bus.mul_done) begin
                    tm_d    = bus.mul_p;
                    state_d = S_COMB;
                end
            end
            S_COMB: begin
                result_d = comb_sum[2*W-1:0];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a0_q       <= '0;
            a1_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            t0_q       <= '0;
            t1_q       <= '0;
            tm_q       <= '0;
            result_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            a0_q       <= a0_d;
            a1_q       <= a1_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            tm_q       <= tm_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.mul_valid = mul_valid;
    assign bus.mul_a     = mul_a;
    assign bus.mul_b     = mul_b;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_karatsuba_seq_ctrl.sv
// Randomised scoreboard bench for karatsuba_seq_ctrl with a behavioural multiplier responder.
module tb_karatsuba_seq_ctrl;
    localparam int W = 256;
    localparam int H = W / 2;

    typedef struct packed {
        logic [H:0] a;
        logic [H:0] b;
    } mpair_t;

    logic clk;
    logic rst;

    karatsuba_seq_ctrl_if #(.W(W)) mif ();

    karatsuba_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_res[$];
    mpair_t         exp_mul[$];
    logic [15:0]    n_done;

    int   mul_delay = 0;
    bit   mul_rand  = 0;
    bit   bp_rand   = 0;
    bit   or_val    = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] r;
        r = rnd_w();
        case ($urandom_range(0, 4))
            0: r = '1;
            1: r[W-1:H] = '1;
            2: r[H-1:0] = '1;
            3: r[W-1:H] = '0;
            default: ;
        endcase
        return r;
    endfunction

    // Expected sub-multiplier operand pairs and final product for one accepted operation.
    task automatic push_expect(input logic [W-1:0] x, input logic [W-1:0] y);
        mpair_t p;
        logic [2*W-1:0] xe, ye;
        p.a = {1'b0, x[H-1:0]};  p.b = {1'b0, y[H-1:0]};  exp_mul.push_back(p);
        p.a = {1'b0, x[W-1:H]};  p.b = {1'b0, y[W-1:H]};  exp_mul.push_back(p);
        p.a = {1'b0, x[H-1:0]} + {1'b0, x[W-1:H]};
        p.b = {1'b0, y[H-1:0]} + {1'b0, y[W-1:H]};
        exp_mul.push_back(p);
        xe = {{W{1'b0}}, x};
        ye = {{W{1'b0}}, y};
        exp_res.push_back(xe * ye);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        @(negedge clk);
        mif.in_valid = 1'b1;
        mif.a = x;
        mif.b = y;
        while (!mif.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!mif.in_ready) check("accept_timeout", 1, 0);
        else push_expect(x, y);
        @(negedge clk);
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!mif.out_valid && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        if (!mif.out_valid) check("out_valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mif.busy || exp_res.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (mif.busy || exp_res.size() != 0) check("idle_timeout", 1, 0);
    endtask

    // Consumer backpressure driver
    initial begin
        mif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mif.out_ready = bp_rand ? 1'($urandom_range(0, 1)) : or_val;
        end
    end

    // Behavioural shared multiplier with configurable wait and spurious done pulses when idle
    logic [H:0] cur_a, cur_b;
    int         wcnt = 0;
    int         tgt  = 0;
    mpair_t     em;
    initial begin
        mif.mul_done = 1'b0;
        mif.mul_p    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                exp_mul.delete();
                wcnt = 0;
                mif.mul_done = 1'b0;
            end else if (mif.mul_valid) begin
                if (wcnt == 0) begin
                    cur_a = mif.mul_a;
                    cur_b = mif.mul_b;
                    if (exp_mul.size() == 0) begin
                        check("mul_unexpected", 1, 0);
                    end else begin
                        em = exp_mul.pop_front();
                        check("mul_a", mif.mul_a, em.a);
                        check("mul_b", mif.mul_b, em.b);
                    end
                    tgt = mul_rand ? int'($urandom_range(0, 3)) : mul_delay;
                end else begin
                    check("mul_a_stable", mif.mul_a, cur_a);
                    check("mul_b_stable", mif.mul_b, cur_b);
                end
                if (wcnt >= tgt) begin
                    mif.mul_done = 1'b1;
                    mif.mul_p    = cur_a * cur_b;
                    wcnt = 0;
                end else begin
                    mif.mul_done = 1'b0;
                    wcnt++;
                end
            end else begin
                check("mul_ops_zero_idle", {mif.mul_a, mif.mul_b}, 0);
                wcnt = 0;
                mif.mul_done = 1'($urandom_range(0, 1));
                mif.mul_p    = {rnd_w(), 2'($urandom_range(0, 3))};
            end
        end
    end

    // Result monitor: pops the scoreboard on every accepted result
    logic [2*W-1:0] er;
    initial begin
        n_done = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_res.delete();
                n_done = '0;
            end else if (mif.out_valid && mif.out_ready) begin
                if (exp_res.size() == 0) begin
                    check("result_unexpected", 1, 0);
                end else begin
                    er = exp_res.pop_front();
                    check("result", mif.result, er);
                end
                check("op_count", mif.op_count, n_done);
                n_done = n_done + 16'd1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    logic [W-1:0]   x, y;
    logic [2*W-1:0] c;
    int             lat;
    initial begin
        rst = 1'b1;
        mif.in_valid = 1'b0;
        mif.a = '0;
        mif.b = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", mif.in_ready, 1);
        check("rst_mul_valid", mif.mul_valid, 0);
        check("rst_out_valid", mif.out_valid, 0);
        check("rst_busy", mif.busy, 0);
        check("rst_result", mif.result, 0);
        check("rst_op_count", mif.op_count, 0);

        // Zero-wait multiplier, minimum latency
        x = '0; x[128] = 1'b1; x[1:0] = 2'd3;
        y = '0; y[128] = 1'b1; y[2:0] = 3'd5;
        do_op(x, y);
        wait_out(lat);
        check("latency_min", lat, 5);
        c = '0; c[256] = 1'b1; c[131] = 1'b1; c[3:0] = 4'hF;
        check("result_const1", mif.result, c);
        wait_idle();
        check("op_count_after1", mif.op_count, 1);

        // Seven wait cycles per sub-product
        mul_delay = 7;
        do_op('1, '1);
        wait_out(lat);
        check("latency_wait7", lat, 5 + 3 * 7);
        c = '0;
        for (int i = 257; i < 2 * W; i++) c[i] = 1'b1;
        c[0] = 1'b1;
        check("result_const2", mif.result, c);
        wait_idle();

        mul_delay = 0;
        do_op('0, '1);
        wait_idle();
        x = 1; y = 1;
        do_op(x, y);
        wait_out(lat);
        check("result_one", mif.result, 1);
        wait_idle();

        // Backpressure: DONE holds and new operands are ignored
        or_val = 1'b0;
        x = rnd_operand(); y = rnd_operand();
        do_op(x, y);
        wait_out(lat);
        c = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        for (int i = 0; i < 20; i++) begin
            mif.in_valid = 1'b1;
            mif.a = rnd_w();
            mif.b = rnd_w();
            @(negedge clk);
            check("bp_out_valid", mif.out_valid, 1);
            check("bp_result", mif.result, c);
            check("bp_in_ready", mif.in_ready, 0);
        end
        mif.in_valid = 1'b0;
        or_val = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", mif.out_valid, 1);
        @(negedge clk);
        check("bp_idle_in_ready", mif.in_ready, 1);
        check("bp_idle_busy", mif.busy, 0);
        repeat (3) @(negedge clk);
        check("bp_no_ghost_op", mif.busy, 0);
        check("op_count_after_bp", mif.op_count, 5);

        // Randomised operands, multiplier waits and consumer stalls
        mul_rand = 1'b1;
        bp_rand  = 1'b1;
        for (int k = 0; k < 30; k++) do_op(rnd_operand(), rnd_operand());
        wait_idle();
        bp_rand  = 1'b0;
        mul_rand = 1'b0;
        check("op_count_after_rand", mif.op_count, 35);

        // Reset in the middle of the second sub-product
        mul_delay = 7;
        x = rnd_operand(); y = rnd_operand();
        do_op(x, y);
        repeat (10) @(negedge clk);
        check("m1_mul_a", mif.mul_a, {1'b0, x[W-1:H]});
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", mif.busy, 0);
        check("midrst_mul_valid", mif.mul_valid, 0);
        check("midrst_out_valid", mif.out_valid, 0);
        check("midrst_result", mif.result, 0);
        check("midrst_op_count", mif.op_count, 0);
        check("midrst_in_ready", mif.in_ready, 1);
        repeat (4) @(negedge clk);
        check("midrst_stays_idle", mif.busy, 0);

        mul_delay = 1;
        do_op(rnd_operand(), rnd_operand());
        wait_idle();
        check("op_count_post_rst", mif.op_count, 1);

        repeat (5) @(negedge clk);
        check("exp_mul_drained", exp_mul.size(), 0);
        check("exp_res_drained", exp_res.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
